skilift_seq: RTL and testbench

- Multi-cycle sequencer for the add / XOR / right-shift transform.
- Each round runs three stages on one shared 64-bit accumulator, one stage per clock: add key, XOR with a fixed mask, shift right.
- Repeats for ROUNDS rounds, then presents the result on a valid/ready output.
- Sits between the challenge-input loader and the flag-compare logic. One transaction in flight at a time.

---
 rtl/skilift_seq.sv | 108 ++++++++++
 tb/tb_skilift_seq.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skilift_seq.sv
// skilift_seq: multi-cycle add / XOR / shift sequencer, one stage per clock.
// Ports: clk, rst_n, in_valid/in_ready/in_data/in_key, out_valid/out_ready/out_data,
// busy, round_idx. Define SKILIFT_ROT_EN to make the shift stage a rotate.
module skilift_seq #(
  parameter int WIDTH  = 64,
  parameter int ROUNDS = 1,
  parameter int SHAMT  = 5,
  parameter logic [WIDTH-1:0] XOR_CONST =
    WIDTH'(64'h4841434B45525321)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [7:0]       round_idx
);

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    XOR,
    SHR,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [7:0]       round_q, round_d;
  logic [WIDTH-1:0] shr_v;

`ifdef SKILIFT_ROT_EN
  assign shr_v = (acc_q >> SHAMT)
               | (acc_q << (WIDTH - SHAMT));
`else
  assign shr_v = acc_q >> SHAMT;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      key_q   <= '0;
      out_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      key_q   <= key_d;
      out_q   <= out_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    key_d   = key_q;
    out_d   = out_q;
    round_d = round_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = in_data;
          key_d   = in_key;
          round_d = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        acc_d   = acc_q + key_q;
        state_d = XOR;
      end
      XOR: begin
        acc_d   = acc_q ^ XOR_CONST;
        state_d = SHR;
      end
      SHR: begin
        acc_d = shr_v;
        if (round_q == 8'(ROUNDS - 1)) begin
          out_d   = shr_v;
          state_d = DONE;
        end else begin
          round_d = round_q + 8'd1;
          state_d = ADD;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_q;
  assign round_idx = round_q;

endmodule

// File: tb/tb_skilift_seq.sv
// tb_skilift_seq: checks two skilift_seq instances (ROUNDS=1 and ROUNDS=2)
// against a cycle-count model plus literal expectations.
module tb_skilift_seq;

  localparam logic [63:0] C = 64'h4841434B45525321;
  localparam logic [63:0] D0 = 64'h5443474D489DFDD3;
  localparam logic [63:0] K0 = 64'h0000000012345678;
`ifdef SKILIFT_ROT_EN
  localparam logic [63:0] EXP_BASIC = 64'h50E0102030FC003B;
  localparam logic [63:0] EXP_CARRY = 64'h0A420A1A5A2A9299;
`else
  localparam logic [63:0] EXP_BASIC = 64'h00E0102030FC003B;
  localparam logic [63:0] EXP_CARRY = 64'h02420A1A5A2A9299;
`endif

  logic        clk;
  logic        rst_n;
  logic        iv[2];
  logic        ir[2];
  logic [63:0] id[2];
  logic [63:0] ik[2];
  logic        ov[2];
  logic        ordy[2];
  logic [63:0] od[2];
  logic        bz[2];
  logic [7:0]  ri[2];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  skilift_seq #(.ROUNDS(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0]), .in_key(ik[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od[0]), .busy(bz[0]),
    .round_idx(ri[0])
  );

  skilift_seq #(.ROUNDS(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1]), .in_key(ik[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od[1]), .busy(bz[1]),
    .round_idx(ri[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference transform: r rounds of add, xor, shift/rotate by 5.
  function automatic logic [63:0] f(
    input logic [63:0] d, input logic [63:0] k, input int r);
    logic [63:0] a;
    a = d;
    for (int i = 0; i < r; i++) begin
      a = a + k;
      a = a ^ C;
`ifdef SKILIFT_ROT_EN
      a = {a[4:0], a[63:5]};
`else
      a = {5'b0, a[63:5]};
`endif
    end
    return a;
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: a transaction keeps the block busy for 3*R stage cycles,
  // then it holds the result until the consumer takes it.
  logic        m_busy[2];
  logic        m_done[2];
  int          m_cnt[2];
  logic [7:0]  m_round[2];
  logic [63:0] m_out[2];
  logic [63:0] m_exp[2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k]  <= 1'b0;
        m_done[k]  <= 1'b0;
        m_cnt[k]   <= 0;
        m_round[k] <= 8'd0;
        m_out[k]   <= 64'd0;
      end else if (!m_busy[k]) begin
        if (iv[k]) begin
          m_busy[k]  <= 1'b1;
          m_cnt[k]   <= 0;
          m_round[k] <= 8'd0;
          m_exp[k]   <= f(id[k], ik[k], k + 1);
        end
      end else if (!m_done[k]) begin
        if (m_cnt[k] + 1 == 3 * (k + 1)) begin
          m_done[k] <= 1'b1;
          m_out[k]  <= m_exp[k];
        end else begin
          m_round[k] <= 8'((m_cnt[k] + 1) / 3);
        end
        m_cnt[k] <= m_cnt[k] + 1;
      end else if (ordy[k]) begin
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d cycle %0d", k, cyc),
          {53'd0, ir[k], ov[k], bz[k], ri[k], od[k]},
          {53'd0, !m_busy[k], m_done[k], m_busy[k],
           m_round[k], m_out[k]});
    end
  end

  task automatic send(input int k, input logic [63:0] d,
                      input logic [63:0] key, input bit hold,
                      output int t);
    id[k] = d;
    ik[k] = key;
    iv[k] = 1'b1;
    t = -1;
    for (int n = 0; n < 200; n++) begin
      if (ir[k]) begin
        @(posedge clk);
        #1;
        t = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!hold) iv[k] = 1'b0;
    if (t < 0) begin
      total++;
      bad++;
      $display("FAIL send timeout dut%0d", k);
    end
  endtask

  task automatic wait_valid(input int k, output int t);
    t = -1;
    for (int n = 0; n < 200; n++) begin
      if (ov[k]) begin
        t = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (t < 0) begin
      total++;
      bad++;
      $display("FAIL valid timeout dut%0d", k);
    end
  endtask

  int ta, tb, tc;
  logic [63:0] hold_d;
  logic [63:0] w[3];
  logic [63:0] kk[3];
  bit done_r;

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0;
      id[k] = '0;
      ik[k] = '0;
      ordy[k] = 1'b1;
    end
    #12;
    chk("reset state", {ir[0], ov[0], bz[0], ri[0], od[0]},
        {1'b1, 1'b0, 1'b0, 8'd0, 64'd0});
    chk("model basic", f(D0, K0, 1), EXP_BASIC);
    chk("model carry", f('1, 64'd1, 1), EXP_CARRY);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic, ROUNDS=1
    send(0, D0, K0, 0, ta);
    wait_valid(0, tb);
    chk("basic latency", tb - ta, 3);
    chk("basic data", od[0], EXP_BASIC);
    @(posedge clk);
    #1;

    // carry wrap
    send(0, '1, 64'd1, 0, ta);
    wait_valid(0, tb);
    chk("carry data", od[0], EXP_CARRY);
    @(posedge clk);
    #1;

    // backpressure
    ordy[0] = 1'b0;
    send(0, 64'h0123456789ABCDEF, 64'h55, 0, ta);
    wait_valid(0, tb);
    hold_d = od[0];
    chk("bp data", hold_d, f(64'h0123456789ABCDEF, 64'h55, 1));
    for (int i = 0; i < 10; i++) begin
      chk("bp in_ready", ir[0], 0);
      chk("bp out_valid", ov[0], 1);
      chk("bp out_data", od[0], hold_d);
      if (i == 3) begin
        iv[0] = 1'b1;
        id[0] = 64'hDEADBEEF;
      end
      if (i == 4) iv[0] = 1'b0;
      @(posedge clk);
      #1;
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release in_ready", ir[0], 1);

    // multi-round, ROUNDS=2
    send(1, D0, K0, 0, ta);
    chk("r2 idx0", ri[1], 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("r2 idx1", ri[1], 1);
    wait_valid(1, tb);
    chk("r2 latency", tb - ta, 6);
    chk("r2 data", od[1], f(D0, K0, 2));
    @(posedge clk);
    #1;

    // async reset during XOR stage
    send(0, D0, K0, 0, ta);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst out_valid", ov[0], 0);
    chk("rst busy", bz[0], 0);
    chk("rst in_ready", ir[0], 1);
    chk("rst out_data", od[0], 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("no stale valid", ov[0], 0);
    end
    send(0, 64'hFEEDFACECAFEF00D, 64'h1234, 0, ta);
    wait_valid(0, tb);
    chk("post-reset data", od[0],
        f(64'hFEEDFACECAFEF00D, 64'h1234, 1));
    @(posedge clk);
    #1;

    // back-to-back with in_valid held high
    for (int i = 0; i < 3; i++) begin
      w[i] = {$urandom, $urandom};
      kk[i] = {$urandom, $urandom};
    end
    send(0, w[0], kk[0], 1, ta);
    send(0, w[1], kk[1], 1, tb);
    send(0, w[2], kk[2], 0, tc);
    chk("b2b spacing 1", tb - ta, 5);
    chk("b2b spacing 2", tc - tb, 5);
    wait_valid(0, ta);
    chk("b2b last data", od[0], f(w[2], kk[2], 1));
    @(posedge clk);
    #1;

    // random traffic with random backpressure
    for (int k = 0; k < 2; k++) begin
      done_r = 0;
      fork
        begin
          for (int n = 0; n < 15; n++) begin
            repeat ($urandom_range(0, 3)) begin
              @(posedge clk);
              #1;
            end
            send(k, {$urandom, $urandom},
                 {$urandom, $urandom}, 0, ta);
          end
          repeat (30) begin
            @(posedge clk);
            #1;
          end
          done_r = 1;
        end
        begin
          while (!done_r) begin
            ordy[k] = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
          end
        end
      join
      ordy[k] = 1'b1;
      repeat (10) begin
        @(posedge clk);
        #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
